multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// on the falling clock edge and drives the datapath strobes for each state.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       target_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegal,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q;
    logic        retire;

    // Next-state, illegal detection and retirement
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = S_EXEC_R;
                    4'b0100:          state_d = S_EXEC_I;
                    4'b0101, 4'b0110: state_d = S_MEM_ADDR;
                    4'b1000, 4'b1001: state_d = S_BRANCH;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: begin
                if (op == 4'b0101) begin
                    state_d = S_MEM_RD;
                end else if (op == 4'b0110) begin
                    state_d = S_MEM_WR;
                end else begin
                    // op changed under a memory instruction; treat as illegal
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (illegal_d) illegal_q <= 1'b1;
            if (retire)    retired_q <= retired_q + 16'd1;
        end
    end

    // Strobes are decoded from the current state; only the FETCH and BRANCH
    // write enables look at mem_ready/zero.
    always_comb begin
        mem_req      = 1'b0;
        i_or_d       = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        target_write = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_ctrl     = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = 3'b010;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b    = 2'b11;
                alu_ctrl     = 3'b010;
                target_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (op)
                    4'b0001: alu_ctrl = 3'b110;
                    4'b0010: alu_ctrl = 3'b000;
                    4'b0011: alu_ctrl = 3'b001;
                    4'b0111: alu_ctrl = 3'b111;
                    default: alu_ctrl = 3'b010;
                endcase
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = 3'b010;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (op != 4'b0100);
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 3'b110;
                pc_src    = 1'b1;
                pc_write  = ((op == 4'b1000) && zero) || ((op == 4'b1001) && !zero);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-written
// expected outputs per cycle, a posedge monitor pops and compares them.
module tb_multicycle_control;

    logic       clk;
    logic       reset, run, zero, mem_ready;
    logic [3:0] op;
    logic       mem_req, i_or_d, mem_write, ir_write, pc_write, pc_src;
    logic       target_write, reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       halted, illegal;
    logic [15:0] retired;

    multicycle_control dut (
        .clk(clk), .reset(reset), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .target_write(target_write), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .state(state), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl layout: mem_req,i_or_d,mem_write,ir_write,pc_write,pc_src,target_write,
    //             reg_dst,reg_write,mem_to_reg,alu_src_a,alu_src_b[1:0],alu_ctrl[2:0]
    localparam logic [15:0] C_IDLE    = 16'b0_0_0_0_0_0_0_0_0_0_0_00_000;
    localparam logic [15:0] C_FETCHW  = 16'b1_0_0_0_0_0_0_0_0_0_0_01_010;
    localparam logic [15:0] C_FETCHR  = 16'b1_0_0_1_1_0_0_0_0_0_0_01_010;
    localparam logic [15:0] C_DEC     = 16'b0_0_0_0_0_0_1_0_0_0_0_11_010;
    localparam logic [15:0] C_EXR_ADD = 16'b0_0_0_0_0_0_0_0_0_0_1_00_010;
    localparam logic [15:0] C_EXI     = 16'b0_0_0_0_0_0_0_0_0_0_1_10_010;
    localparam logic [15:0] C_MRD     = 16'b1_1_0_0_0_0_0_0_0_0_0_00_000;
    localparam logic [15:0] C_MWR     = 16'b1_1_1_0_0_0_0_0_0_0_0_00_000;
    localparam logic [15:0] C_WBR     = 16'b0_0_0_0_0_0_0_1_1_0_0_00_000;
    localparam logic [15:0] C_WBI     = 16'b0_0_0_0_0_0_0_0_1_0_0_00_000;
    localparam logic [15:0] C_WBM     = 16'b0_0_0_0_0_0_0_0_1_1_0_00_000;
    localparam logic [15:0] C_BRT     = 16'b0_0_0_0_1_1_0_0_0_0_1_00_110;
    localparam logic [15:0] C_BRN     = 16'b0_0_0_0_0_1_0_0_0_0_1_00_110;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        h;
        logic        il;
        logic [15:0] ret;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;
    logic        h_exp, i_exp;
    logic [15:0] r_exp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: sampled on posedge, opposite to the DUT's negedge.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check("state", {12'd0, state}, {12'd0, e.st});
            check("ctl", {mem_req, i_or_d, mem_write, ir_write, pc_write, pc_src, target_write,
                          reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl}, e.ctl);
            check("halted_illegal", {14'd0, halted, illegal}, {14'd0, e.h, e.il});
            check("retired", retired, e.ret);
        end
    end

    task automatic drive(input logic rs, input logic rn, input logic [3:0] o,
                         input logic z, input logic mr);
        @(negedge clk);
        #1;
        reset = rs; run = rn; op = o; zero = z; mem_ready = mr;
    endtask

    // Apply inputs for the state just entered and queue its expected outputs.
    task automatic step(input logic rs, input logic rn, input logic [3:0] o, input logic z,
                        input logic mr, input logic [3:0] es, input logic [15:0] ec);
        exp_t x;
        drive(rs, rn, o, z, mr);
        x.st = es; x.ctl = ec; x.h = h_exp; x.il = i_exp; x.ret = r_exp;
        q.push_back(x);
    endtask

    logic [3:0]  rops  [4] = '{4'd1, 4'd2, 4'd3, 4'd7};
    logic [2:0]  rctl  [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
    logic [3:0]  bops  [4] = '{4'd8, 4'd9, 4'd8, 4'd9};
    logic        bzs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] bctls [4] = '{C_BRT, C_BRN, C_BRN, C_BRT};

    initial begin
        reset = 1'b1; run = 1'b0; op = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        h_exp = 1'b0; i_exp = 1'b0; r_exp = 16'd0;
        drive(1, 0, 0, 0, 1);
        // reset state; reset with run=1 must keep IDLE
        step(1, 1, 0, 0, 1, 4'd0, C_IDLE);
        step(0, 0, 0, 0, 1, 4'd0, C_IDLE);
        step(0, 1, 0, 0, 1, 4'd0, C_IDLE);
        // ADD, run dropped mid-instruction
        step(0, 1, 0, 0, 1, 4'd1, C_FETCHR);
        step(0, 1, 0, 0, 1, 4'd2, C_DEC);
        step(0, 0, 0, 0, 1, 4'd3, C_EXR_ADD);
        step(0, 0, 0, 0, 1, 4'd8, C_WBR);
        r_exp = 16'd1;
        // LW with three wait cycles
        step(0, 0, 5, 0, 1, 4'd1, C_FETCHR);
        step(0, 0, 5, 0, 1, 4'd2, C_DEC);
        step(0, 0, 5, 0, 1, 4'd5, C_EXI);
        repeat (3) step(0, 0, 5, 0, 0, 4'd6, C_MRD);
        step(0, 0, 5, 0, 1, 4'd6, C_MRD);
        step(0, 0, 5, 0, 1, 4'd9, C_WBM);
        r_exp = 16'd2;
        // SW with fetch wait and write wait
        step(0, 0, 6, 0, 0, 4'd1, C_FETCHW);
        step(0, 0, 6, 0, 1, 4'd1, C_FETCHR);
        step(0, 0, 6, 0, 1, 4'd2, C_DEC);
        step(0, 0, 6, 0, 1, 4'd5, C_EXI);
        step(0, 0, 6, 0, 0, 4'd7, C_MWR);
        step(0, 0, 6, 0, 1, 4'd7, C_MWR);
        r_exp = 16'd3;
        // BEQ/BNE taken and not taken
        for (int k = 0; k < 4; k++) begin
            step(0, 0, bops[k], bzs[k], 1, 4'd1, C_FETCHR);
            step(0, 0, bops[k], bzs[k], 1, 4'd2, C_DEC);
            step(0, 0, bops[k], bzs[k], 1, 4'd10, bctls[k]);
            r_exp = r_exp + 16'd1;
        end
        // ADDI
        step(0, 0, 4, 0, 1, 4'd1, C_FETCHR);
        step(0, 0, 4, 0, 1, 4'd2, C_DEC);
        step(0, 0, 4, 0, 1, 4'd4, C_EXI);
        step(0, 0, 4, 0, 1, 4'd8, C_WBI);
        r_exp = 16'd8;
        // remaining R-type ALU codes
        for (int k = 0; k < 4; k++) begin
            step(0, 0, rops[k], 0, 1, 4'd1, C_FETCHR);
            step(0, 0, rops[k], 0, 1, 4'd2, C_DEC);
            step(0, 0, rops[k], 0, 1, 4'd3, (C_EXR_ADD & ~16'h0007) | {13'd0, rctl[k]});
            step(0, 0, rops[k], 0, 1, 4'd8, C_WBR);
            r_exp = r_exp + 16'd1;
        end
        // reset during a fetch wait
        step(0, 0, 0, 0, 0, 4'd1, C_FETCHW);
        step(1, 0, 0, 0, 0, 4'd1, C_FETCHW);
        r_exp = 16'd0;
        step(0, 0, 0, 0, 1, 4'd0, C_IDLE);
        // illegal opcode halts and ignores run
        step(0, 1, 15, 0, 1, 4'd0, C_IDLE);
        step(0, 0, 15, 0, 1, 4'd1, C_FETCHR);
        step(0, 0, 15, 0, 1, 4'd2, C_DEC);
        h_exp = 1'b1; i_exp = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(0, k[0], 15, k[1], 1, 4'd11, C_IDLE);
        end
        step(1, 1, 15, 0, 1, 4'd11, C_IDLE);
        h_exp = 1'b0; i_exp = 1'b0;
        step(0, 0, 0, 0, 1, 4'd0, C_IDLE);
        // retired wrap from FFFF
        @(negedge clk);
        #1 force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        r_exp = 16'hFFFF;
        step(0, 1, 4, 0, 1, 4'd0, C_IDLE);
        step(0, 0, 4, 0, 1, 4'd1, C_FETCHR);
        step(0, 0, 4, 0, 1, 4'd2, C_DEC);
        step(0, 0, 4, 0, 1, 4'd4, C_EXI);
        step(0, 0, 4, 0, 1, 4'd8, C_WBI);
        r_exp = 16'd0;
        step(0, 0, 4, 0, 0, 4'd1, C_FETCHW);
        repeat (3) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
